// File: rtl/interrupt_ack_controller.sv
// 8259-style interrupt acknowledge sequencer: INTA handshake, ISR, rotation pointer, vector byte, OCW2.
// Optional automatic EOI support is enabled by defining PIC_AUTO_EOI_EN.
module interrupt_ack_controller (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_interrupt,
  input  logic       i_inta_n,
  input  logic [4:0] i_vector_base,
  input  logic       i_auto_eoi_config,
  input  logic       i_ocw2_write,
  input  logic [7:0] i_ocw2_data,
  output logic [7:0] o_in_service_register,
  output logic [2:0] o_priority_rotate,
  output logic       o_int_out,
  output logic [7:0] o_irr_clear,
  output logic [7:0] o_data_out,
  output logic       o_data_out_enable
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PENDING = 3'd1,
    ACK1    = 3'd2,
    WAIT2   = 3'd3,
    VECTOR  = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_inta_prev;
  logic       w_fall;
  logic       w_rise;
  logic [2:0] r_level;
  logic       r_spurious;
  logic [7:0] r_isr;
  logic [2:0] r_rotate;
  logic       r_int_out;
  logic [7:0] r_irr_clear;
  logic [7:0] r_data_out;
  logic       r_data_out_enable;

  logic       w_aeoi_active;
  logic       w_rotate_in_aeoi;
  logic       w_unused;

  logic       w_ack_take;
  logic       w_ack_valid;
  logic [2:0] w_ack_level;
  logic [7:0] w_set_mask;
  logic [2:0] w_level_next;
  logic       w_spurious_next;
  logic       w_aeoi_done;
  logic [7:0] w_aeoi_clear;
  logic       w_eoi_found;
  logic [2:0] w_eoi_level;
  logic [7:0] w_ocw2_clear;
  logic [2:0] w_rotate_next;
  logic [7:0] w_isr_next;
  logic [2:0] w_cmd;
  logic [2:0] w_cmd_level;

  assign w_fall      = r_inta_prev & ~i_inta_n;
  assign w_rise      = ~r_inta_prev & i_inta_n;
  assign w_cmd       = i_ocw2_data[7:5];
  assign w_cmd_level = i_ocw2_data[2:0];

`ifdef PIC_AUTO_EOI_EN
  logic r_rotate_in_aeoi;
  logic w_rotate_in_aeoi_next;

  assign w_aeoi_active    = i_auto_eoi_config;
  assign w_rotate_in_aeoi = r_rotate_in_aeoi;
  assign w_unused         = ^i_ocw2_data[4:3];

  always_comb begin
    w_rotate_in_aeoi_next = r_rotate_in_aeoi;
    if (i_ocw2_write && (w_cmd == 3'b100)) w_rotate_in_aeoi_next = 1'b1;
    if (i_ocw2_write && (w_cmd == 3'b000)) w_rotate_in_aeoi_next = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_rotate_in_aeoi <= 1'b0;
    else          r_rotate_in_aeoi <= w_rotate_in_aeoi_next;
  end
`else
  assign w_aeoi_active    = 1'b0;
  assign w_rotate_in_aeoi = 1'b0;
  assign w_unused         = ^{i_auto_eoi_config, i_ocw2_data[4:3]};
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (|i_interrupt) w_next_state = PENDING;
      PENDING: if (w_fall)       w_next_state = ACK1;
      ACK1:    if (w_rise)       w_next_state = WAIT2;
      WAIT2:   if (w_fall)       w_next_state = VECTOR;
      VECTOR:  if (w_rise)       w_next_state = IDLE;
      default:                   w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_ack_valid = |i_interrupt;
    w_ack_level = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (i_interrupt[i]) w_ack_level = 3'(i);
    end

    w_ack_take      = (r_state == PENDING) && w_fall;
    w_set_mask      = (w_ack_take && w_ack_valid) ? (8'b0000_0001 << w_ack_level) : 8'h00;
    w_level_next    = w_ack_take ? (w_ack_valid ? w_ack_level : 3'd7) : r_level;
    w_spurious_next = w_ack_take ? ~w_ack_valid : r_spurious;

    w_aeoi_done  = (r_state == VECTOR) && w_rise && w_aeoi_active && !r_spurious;
    w_aeoi_clear = w_aeoi_done ? (8'b0000_0001 << r_level) : 8'h00;

    // Non-specific EOI picks the highest-priority in-service level, starting just above the rotate pointer.
    w_eoi_found = 1'b0;
    w_eoi_level = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!w_eoi_found && r_isr[r_rotate + 3'(i + 1)]) begin
        w_eoi_found = 1'b1;
        w_eoi_level = r_rotate + 3'(i + 1);
      end
    end

    w_ocw2_clear  = 8'h00;
    w_rotate_next = r_rotate;
    if (w_aeoi_done && w_rotate_in_aeoi) w_rotate_next = r_level;
    if (i_ocw2_write) begin
      case (w_cmd)
        3'b001: if (w_eoi_found) w_ocw2_clear = 8'b0000_0001 << w_eoi_level;
        3'b101: begin
          if (w_eoi_found) begin
            w_ocw2_clear  = 8'b0000_0001 << w_eoi_level;
            w_rotate_next = w_eoi_level;
          end
        end
        3'b011: w_ocw2_clear = 8'b0000_0001 << w_cmd_level;
        3'b111: begin
          w_ocw2_clear  = 8'b0000_0001 << w_cmd_level;
          w_rotate_next = w_cmd_level;
        end
        3'b110: w_rotate_next = w_cmd_level;
        default: ;
      endcase
    end

    // Clears use the pre-cycle ISR; an acknowledge set on the same bit takes precedence.
    w_isr_next = (r_isr & ~(w_ocw2_clear | w_aeoi_clear)) | w_set_mask;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_inta_prev       <= 1'b1;
      r_level           <= 3'd0;
      r_spurious        <= 1'b0;
      r_isr             <= 8'h00;
      r_rotate          <= 3'b111;
      r_int_out         <= 1'b0;
      r_irr_clear       <= 8'h00;
      r_data_out        <= 8'h00;
      r_data_out_enable <= 1'b0;
    end else begin
      r_inta_prev       <= i_inta_n;
      r_level           <= w_level_next;
      r_spurious        <= w_spurious_next;
      r_isr             <= w_isr_next;
      r_rotate          <= w_rotate_next;
      r_int_out         <= (w_next_state == PENDING);
      r_irr_clear       <= w_set_mask;
      r_data_out        <= (w_next_state == VECTOR) ? {i_vector_base, w_level_next} : 8'h00;
      r_data_out_enable <= (w_next_state == VECTOR);
    end
  end

  assign o_in_service_register = r_isr;
  assign o_priority_rotate     = r_rotate;
  assign o_int_out             = r_int_out;
  assign o_irr_clear           = r_irr_clear;
  assign o_data_out            = r_data_out;
  assign o_data_out_enable     = r_data_out_enable;

endmodule

// File: doc/interrupt_ack_controller.md
# interrupt_ack_controller

Sequences the 8259 interrupt acknowledge cycle around the priority resolver. Raises INT when the resolver reports a winning request, runs the two-pulse INTA handshake, owns the in-service register and the rotation pointer fed back to the resolver, drives the vector byte, and executes OCW2 end-of-interrupt and rotation commands.

## Interface
- No parameters.
- `clk` in 1: system clock; all state changes on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `interrupt` in 8: one-hot winner from the priority resolver; all-zero means none.
- `inta_n` in 1: interrupt acknowledge, active-low, already synchronous to `clk`.
- `vector_base` in 5: ICW2 T7–T3.
- `auto_eoi_config` in 1: ICW4 AEOI bit.
- `ocw2_write` in 1: one-cycle strobe; `ocw2_data` is valid.
- `ocw2_data` in 8: [7:5] = R, SL, EOI; [2:0] = level L.
- `in_service_register` out 8: ISR, to the resolver.
- `priority_rotate` out 3: lowest-priority IR level, to the resolver. The highest-priority level is (priority_rotate+1) mod 8.
- `int_out` out 1: INT pin.
- `irr_clear` out 8: one-cycle one-hot pulse that clears the acknowledged IRR bit.
- `data_out` out 8: vector byte.
- `data_out_enable` out 1: drive enable for `data_out`.

## Operation
- States: IDLE, PENDING, ACK1, WAIT2, VECTOR.
- Edge detect: `inta_prev` is registered and resets to 1.
  - fall = prev & ~inta_n.
  - rise = ~prev & inta_n.
- IDLE:
  - `int_out`=0.
  - If `interrupt`≠0, go to PENDING.
- PENDING:
  - `int_out`=1.
  - `interrupt` returning to 0 does not leave PENDING.
  - On fall, latch the level and go to ACK1:
    - If `interrupt`≠0, level = index of the set bit. Set ISR[level] and pulse `irr_clear`[level].
    - If `interrupt`=0, this is spurious: level=7, ISR unchanged, no `irr_clear`.
- ACK1: on rise, go to WAIT2.
- WAIT2: on fall, go to VECTOR.
- VECTOR:
  - `data_out`={vector_base, level}.
  - On rise, go to IDLE. If AEOI is active and the interrupt was not spurious:
    - Clear ISR[level].
    - If `rotate_in_aeoi`=1, set `priority_rotate`=level.
- `int_out` deasserts in the cycle ACK1 is entered.
- `interrupt` is ignored outside IDLE and PENDING.
- OCW2 decode (R,SL,EOI). It is accepted in any state.
  - 001, non-specific EOI: clear the highest-priority set ISR bit, scanning from (priority_rotate+1) mod 8 upward with wrap. If ISR=0, no effect.
  - 101: same as 001, and additionally set `priority_rotate` = the cleared level. If ISR=0, no rotation.
  - 011, specific EOI: clear ISR[L].
  - 111: clear ISR[L] and set `priority_rotate`=L.
  - 110, set priority: `priority_rotate`=L.
  - 100: `rotate_in_aeoi`=1.
  - 000: `rotate_in_aeoi`=0.
  - 010: no operation.
- Simultaneous events in one cycle:
  - EOI clear is computed from the pre-cycle ISR, then the acknowledge set is applied; the set wins on the same bit.
  - If OCW2 and AEOI both update `priority_rotate`, OCW2 wins.

## Timing
- Reset values:
  - state=IDLE, ISR=0, `priority_rotate`=3'b111, `rotate_in_aeoi`=0.
  - `int_out`=0, `irr_clear`=0, `data_out`=0, `data_out_enable`=0.
- All outputs are registered.
- Latencies:
  - `int_out` rises 1 cycle after `interrupt`≠0 is sampled in IDLE.
  - ISR bit and `irr_clear` appear 1 cycle after the first fall is sampled. `irr_clear` is exactly 1 cycle wide.
  - `data_out_enable`=1 from 1 cycle after the second fall through the cycle the second rise is sampled. It is 0 in the following cycle.
  - AEOI clear is visible 1 cycle after the second rise.
  - `int_out` can re-rise 1 cycle after returning to IDLE if `interrupt`≠0.
- OCW2 effects are visible 1 cycle after the `ocw2_write` strobe.
- `rst_n` low in any state forces reset values on the next edge. An INTA sequence in progress is abandoned with no ISR clear.

## Configuration
- `PIC_AUTO_EOI_EN` defined:
  - `auto_eoi_config` is honoured.
  - `rotate_in_aeoi` and OCW2 commands 100/000 are implemented as above.
- `PIC_AUTO_EOI_EN` undefined:
  - `auto_eoi_config` is ignored (port retained).
  - ISR bits clear only via OCW2 EOI commands.
  - 100/000 are no-ops; `rotate_in_aeoi` is constant 0.

## Test plan
- Basic acknowledge:
  - Stimulus: `interrupt`=8'h08, `vector_base`=5'h10, two INTA pulses.
  - Response: `int_out`=1, then ISR=8'h08, `irr_clear`=8'h08 for 1 cycle, `data_out`=8'h83 with enable high during pulse 2, ISR stays 8'h08.
- Spurious:
  - Stimulus: `interrupt` 8'h04 for 2 cycles, then 0 before the first INTA.
  - Response: ISR=0, no `irr_clear`, `data_out`={vector_base,3'b111}.
- Rotating non-specific EOI:
  - Stimulus: ISR=8'h24, `priority_rotate`=7, OCW2=8'hA0.
  - Response: ISR=8'h20, `priority_rotate`=2. A following OCW2=8'h20 gives ISR=0. A further 8'hA0 leaves `priority_rotate`=2.
- Wrap-around:
  - Stimulus: `priority_rotate`=4, ISR=8'h81, OCW2=8'h20.
  - Response: ISR=8'h01, since IR7 outranks IR0.
- AEOI (with `PIC_AUTO_EOI_EN`):
  - Stimulus: `auto_eoi_config`=1, OCW2=8'h80, acknowledge IR5.
  - Response: ISR returns to 0 one cycle after the second rise; `priority_rotate`=5.
- Collision and reset:
  - Stimulus: OCW2=8'h63 (specific EOI L=3) in the same cycle as the first fall with `interrupt`=8'h08.
  - Response: ISR[3]=1.
  - Stimulus: `rst_n` low during VECTOR.
  - Response: all reset values next cycle, `data_out_enable`=0.
